// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS core mul/div path.
// Op encodings, FSM states and the iteration count.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } muldiv_state_t;

  localparam int MULDIV_STEPS = 32;

endpackage

// File: rtl/mips_cpu_muldiv_sign.sv
// Conditional two's-complement negate (abs / sign fix-up).
// Ports: val in, neg in (negate when 1), res out.
module mips_cpu_muldiv_sign #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO file.
// Ports: clk, reset, start, op, a, b -> busy, data_hi/lo, hi_en/lo_en.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] data_hi,
  output logic [WIDTH-1:0] data_lo,
  output logic             hi_en,
  output logic             lo_en
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  muldiv_state_t state, state_nxt;
  muldiv_op_t    op_in, op_r;

  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc, acc_nxt;
  logic [WIDTH-1:0] a_mag_r, b_mag_r, a_raw_r;
  logic             neg_q_r, neg_r_r;

  logic             sgn_in, neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             last, fin_load, is_div;

  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             q_bit;

  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_in  = muldiv_op_t'(op);
  assign sgn_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign neg_a  = sgn_in & a[WIDTH-1];
  assign neg_b  = sgn_in & b[WIDTH-1];

  mips_cpu_muldiv_sign #(.W(WIDTH)) u_abs_a (
    .val(a), .neg(neg_a), .res(a_mag)
  );

  mips_cpu_muldiv_sign #(.W(WIDTH)) u_abs_b (
    .val(b), .neg(neg_b), .res(b_mag)
  );

  assign is_div   = (op_r == OP_DIV) || (op_r == OP_DIVU);
  assign last     = (cnt == CW'(MULDIV_STEPS - 1));
  assign fin_load = (state == ST_RUN) && last;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start) state_nxt = ST_RUN;
      ST_RUN:    if (last) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Multiply: add multiplicand into the high half, then shift
  // the whole accumulator right (multiplier bit cnt, LSB first).
  // Divide: remainder lives in the high half, quotient shifts in
  // at bit 0; dividend bits are pulled in MSB first.
  always_comb begin
    mul_sum  = {1'b0, acc[AW-1:WIDTH]}
             + (b_mag_r[cnt] ? {1'b0, a_mag_r} : '0);
    div_sh   = {acc[AW-1:WIDTH], a_mag_r[CW'(WIDTH-1) - cnt]};
    div_diff = div_sh - {1'b0, b_mag_r};
    q_bit    = ~div_diff[WIDTH];
    if (is_div) begin
      acc_nxt = {q_bit ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0],
                 acc[WIDTH-2:0], q_bit};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  mips_cpu_muldiv_sign #(.W(AW)) u_fix_prod (
    .val(acc_nxt), .neg(neg_q_r), .res(prod_fix)
  );

  mips_cpu_muldiv_sign #(.W(WIDTH)) u_fix_quo (
    .val(acc_nxt[WIDTH-1:0]), .neg(neg_q_r), .res(quo_fix)
  );

  mips_cpu_muldiv_sign #(.W(WIDTH)) u_fix_rem (
    .val(acc_nxt[AW-1:WIDTH]), .neg(neg_r_r), .res(rem_fix)
  );

  // Divide by zero bypasses the datapath result entirely.
  always_comb begin
    res_hi = prod_fix[AW-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_mag_r == '0) begin
        res_hi = a_raw_r;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_r    <= OP_MULT;
      cnt     <= '0;
      acc     <= '0;
      a_mag_r <= '0;
      b_mag_r <= '0;
      a_raw_r <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      busy    <= 1'b0;
      hi_en   <= 1'b0;
      lo_en   <= 1'b0;
      data_hi <= '0;
      data_lo <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      hi_en <= fin_load;
      lo_en <= fin_load;
      if (state == ST_IDLE && start) begin
        op_r    <= op_in;
        cnt     <= '0;
        acc     <= '0;
        a_mag_r <= a_mag;
        b_mag_r <= b_mag;
        a_raw_r <= a;
        neg_q_r <= neg_a ^ neg_b;
        neg_r_r <= neg_a;
      end else if (state == ST_RUN) begin
        acc <= acc_nxt;
        cnt <= cnt + CW'(1);
      end
      if (fin_load) begin
        data_hi <= res_hi;
        data_lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Bench for mips_cpu_muldiv: arithmetic reference model,
// per-cycle compare, directed literals and random traffic.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, hi_en, lo_en;
  logic [31:0] data_hi, data_lo;

  int checks = 0;
  int errors = 0;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .data_hi(data_hi),
    .data_lo(data_lo), .hi_en(hi_en), .lo_en(lo_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // {hi, lo} from plain arithmetic
  function automatic logic [63:0] ref_op(input logic [1:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy;
    int qi, ri;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0;
    case (o)
      2'b00: r = 64'(sx * sy);
      2'b01: r = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          r = {32'h0, 32'h80000000};
        else begin
          qi = $signed(x) / $signed(y);
          ri = $signed(x) % $signed(y);
          r = {32'(ri), 32'(qi)};
        end
      end
      default: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // Timeline model: cycle index since accept, 0 = idle.
  int          m_cyc = 0;
  logic        m_busy = 1'b0;
  logic        m_en = 1'b0;
  logic [63:0] m_res = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    int nc;
    nc = m_cyc;
    if (reset) begin
      nc = 0;
      m_res <= '0;
    end else if (m_cyc == 0) begin
      if (start) begin
        m_pend <= ref_op(op, a, b);
        nc = 1;
      end
    end else begin
      nc = m_cyc + 1;
      if (nc == 33) m_res <= m_pend;
      if (nc == 34) nc = 0;
    end
    m_cyc  <= nc;
    m_busy <= (nc != 0);
    m_en   <= (nc == 33);
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("hi_en", 64'(hi_en), 64'(m_en));
    chk("lo_en", 64'(lo_en), 64'(m_en));
    chk("data_hi", 64'(data_hi), 64'(m_res[63:32]));
    chk("data_lo", 64'(data_lo), 64'(m_res[31:0]));
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_en(input int cur, input int exp_cyc,
                         input logic [31:0] hi, input logic [31:0] lo);
    int k;
    bit seen;
    k = cur;
    seen = 0;
    while (!seen && k < cur + 50) begin
      @(negedge clk);
      k++;
      if (hi_en) seen = 1;
    end
    chk("en_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("en_cycle", 64'(k), 64'(exp_cyc));
      chk("lit_hi", 64'(data_hi), 64'(hi));
      chk("lit_lo", 64'(data_lo), 64'(lo));
      @(negedge clk);
      chk("busy_after", 64'(busy), 64'd0);
    end
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x, y, hi, lo;
  } vec_t;

  vec_t vecs[7] = '{
    '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
    '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB},
    '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14},
    '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD},
    '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF},
    '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF}
  };

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(data_hi), 64'd0);
    chk("rst_lo", 64'(data_lo), 64'd0);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].x, vecs[i].y);
      wait_en(1, 33, vecs[i].hi, vecs[i].lo);
    end

    // start while busy is ignored
    issue(2'b01, 32'd100, 32'd200);
    repeat (4) @(negedge clk);
    #1 start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
    @(negedge clk); #1 start = 1'b0;
    wait_en(6, 33, 32'd0, 32'd20000);

    // reset mid-run, then restart
    issue(2'b01, 32'd100, 32'd200);
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("busy_c11", 64'(busy), 64'd0);
    #1 reset = 1'b0;
    issue(2'b11, 32'd100, 32'd7);
    wait_en(13, 45, 32'd2, 32'd14);

    // random traffic, model follows every cycle
    repeat (4000) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 5) == 0);
      op    = 2'($urandom);
      a     = pick();
      b     = pick();
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
